// File: rtl/surf_cin_pkg.sv
// Shared types and constants for the CIN receiver.
// Optional error counter is enabled by SURF_CIN_ERRCNT_EN.
package surf_cin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEARCH,
    ST_SLIP_WAIT,
    ST_VERIFY,
    ST_LOCKED,
    ST_FAIL
  } state_t;

  localparam logic [31:0] TRAIN_DEFAULT = 32'hA55A6996;
  localparam int SLIP_WAIT_CYCLES = 4;
  localparam int NUM_SLIPS = 8;

endpackage

// File: rtl/surf_cin_if.sv
// CIN receiver data/status bundle.
// errcnt_o exists only with SURF_CIN_ERRCNT_EN.
interface surf_cin_if;

  logic [7:0]  cin_data_i;
  logic        align_start_i;
  logic        bitslip_o;
  logic        locked_o;
  logic        align_fail_o;
  logic [31:0] command_o;
  logic        command_valid_o;
`ifdef SURF_CIN_ERRCNT_EN
  logic [15:0] errcnt_o;
`endif

  modport master (
    output cin_data_i, align_start_i,
    input  bitslip_o, locked_o, align_fail_o,
    input  command_o, command_valid_o
`ifdef SURF_CIN_ERRCNT_EN
    , input errcnt_o
`endif
  );

  modport slave (
    input  cin_data_i, align_start_i,
    output bitslip_o, locked_o, align_fail_o,
    output command_o, command_valid_o
`ifdef SURF_CIN_ERRCNT_EN
    , output errcnt_o
`endif
  );

endinterface

// File: rtl/surf_cin_window.sv
// Byte shift window with optional inversion and
// training-word comparator.
module surf_cin_window
  import surf_cin_pkg::*;
#(
  parameter logic [31:0] TRAIN_SEQUENCE = TRAIN_DEFAULT,
  parameter bit          CIN_INV        = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  cin_data,
  output logic [31:0] window,
  output logic        match
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) window <= '0;
    else     window <= {window[23:0], cin_data ^ {8{CIN_INV}}};
  end

  assign match = (window == TRAIN_SEQUENCE);

endmodule

// File: rtl/surf_cin_receiver.sv
// CIN word aligner and command decoder.
// SURF_CIN_ERRCNT_EN adds the near-training error counter.
module surf_cin_receiver
  import surf_cin_pkg::*;
#(
  parameter logic [31:0] TRAIN_SEQUENCE = TRAIN_DEFAULT,
  parameter bit          CIN_INV        = 1'b0,
  parameter int          LOCK_COUNT     = 4,
  parameter int          SEARCH_CYCLES  = 8
) (
  input  logic      sysclk_i,
  input  logic      sysclk_rst_i,
  surf_cin_if.slave cin
);

  localparam int          SLIP_W    = $clog2(NUM_SLIPS);
  localparam logic [3:0]  LOCK_N    = 4'(LOCK_COUNT);
  localparam logic [7:0]  SRCH_LAST = 8'(SEARCH_CYCLES - 1);
  localparam logic [1:0]  WAIT_LAST = 2'(SLIP_WAIT_CYCLES - 1);
  localparam logic [15:0] TRAIN_HI  = TRAIN_SEQUENCE[31:16];

  logic [31:0] window;
  logic        match;

  state_t              state_q, state_n;
  logic [1:0]          phase_q, phase_n;
  logic [SLIP_W-1:0]   slip_q, slip_n;
  logic [3:0]          mcnt_q, mcnt_n;
  logic [7:0]          srch_q, srch_n;
  logic [1:0]          wait_q, wait_n;
  logic                bslip_q, bslip_n;
  logic                fail_q, fail_n;
  logic [31:0]         cmd_q, cmd_n;
  logic                vld_q, vld_n;
  logic                boundary;

  surf_cin_window #(
    .TRAIN_SEQUENCE (TRAIN_SEQUENCE),
    .CIN_INV        (CIN_INV)
  ) u_window (
    .clk      (sysclk_i),
    .rst      (sysclk_rst_i),
    .cin_data (cin.cin_data_i),
    .window   (window),
    .match    (match)
  );

  // phase 3 marks a full word in the window
  assign boundary = (phase_q == 2'd3);

`ifdef SURF_CIN_ERRCNT_EN
  logic [15:0] err_q, err_n;
  logic        near_hit;

  assign near_hit = (window[31:16] == TRAIN_HI) && !match;
  assign cin.errcnt_o = err_q;

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) err_q <= '0;
    else              err_q <= err_n;
  end

  always_comb begin
    err_n = err_q;
    if (cin.align_start_i)
      err_n = '0;
    else if (state_q == ST_LOCKED && boundary
             && near_hit && err_q != 16'hFFFF)
      err_n = err_q + 16'd1;
  end
`endif

  always_ff @(posedge sysclk_i or posedge sysclk_rst_i) begin
    if (sysclk_rst_i) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      slip_q  <= '0;
      mcnt_q  <= '0;
      srch_q  <= '0;
      wait_q  <= '0;
      bslip_q <= 1'b0;
      fail_q  <= 1'b0;
      cmd_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      phase_q <= phase_n;
      slip_q  <= slip_n;
      mcnt_q  <= mcnt_n;
      srch_q  <= srch_n;
      wait_q  <= wait_n;
      bslip_q <= bslip_n;
      fail_q  <= fail_n;
      cmd_q   <= cmd_n;
      vld_q   <= vld_n;
    end
  end

  always_comb begin
    state_n = state_q;
    phase_n = phase_q + 2'd1;
    slip_n  = slip_q;
    mcnt_n  = mcnt_q;
    srch_n  = srch_q;
    wait_n  = wait_q;
    bslip_n = 1'b0;
    fail_n  = fail_q;
    cmd_n   = cmd_q;
    vld_n   = 1'b0;
    if (cin.align_start_i) begin
      state_n = ST_SEARCH;
      slip_n  = '0;
      mcnt_n  = '0;
      srch_n  = '0;
      wait_n  = '0;
      fail_n  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_SEARCH: begin
          if (match) begin
            phase_n = '0;
            mcnt_n  = 4'd1;
            state_n = (LOCK_N == 4'd1) ? ST_LOCKED : ST_VERIFY;
          end else if (srch_q == SRCH_LAST) begin
            bslip_n = 1'b1;
            slip_n  = slip_q + 1'b1;
            wait_n  = '0;
            state_n = ST_SLIP_WAIT;
          end else begin
            srch_n = srch_q + 8'd1;
          end
        end
        ST_SLIP_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            srch_n  = '0;
            state_n = (slip_q == '0) ? ST_FAIL : ST_SEARCH;
          end else begin
            wait_n = wait_q + 2'd1;
          end
        end
        ST_VERIFY: begin
          if (boundary && match) begin
            mcnt_n = mcnt_q + 4'd1;
            if (mcnt_n == LOCK_N) state_n = ST_LOCKED;
          end else if (boundary) begin
            bslip_n = 1'b1;
            slip_n  = slip_q + 1'b1;
            wait_n  = '0;
            state_n = ST_SLIP_WAIT;
          end
        end
        ST_LOCKED: begin
          if (boundary && !match) begin
            cmd_n = window;
            vld_n = 1'b1;
          end
        end
        ST_FAIL: begin
          fail_n  = 1'b1;
          state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  assign cin.bitslip_o       = bslip_q;
  assign cin.locked_o        = (state_q == ST_LOCKED);
  assign cin.align_fail_o    = fail_q;
  assign cin.command_o       = cmd_q;
  assign cin.command_valid_o = vld_q;

endmodule

// File: tb/tb_surf_cin_receiver.sv
// Scoreboard bench for surf_cin_receiver with a bit-level
// ISERDES model that honours bitslip.
module tb_surf_cin_receiver;

  localparam logic [31:0] TRAIN = 32'hA55A6996;

  logic clk = 1'b0;
  logic rst = 1'b1;

  surf_cin_if cif();

  surf_cin_receiver dut (
    .sysclk_i     (clk),
    .sysclk_rst_i (rst),
    .cin          (cif.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int slips = 0;
  int valids = 0;
  int slip_cyc[$];
  logic [31:0] exp_q[$];
  logic [31:0] inj_q[$];
  bit bq[$];
  bit zero_mode = 1'b0;
  logic prev_slip = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h",
                  name, act, exp);
  endtask

  task automatic fill();
    logic [31:0] w;
    while (bq.size() < 64) begin
      if (inj_q.size() > 0) w = inj_q.pop_front();
      else if (zero_mode)   w = 32'h0;
      else                  w = TRAIN;
      for (int i = 31; i >= 0; i--) bq.push_back(w[i]);
    end
  endtask

  // serializer model: one byte per cycle, MSB oldest
  initial begin
    logic [7:0] b;
    cif.cin_data_i = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      fill();
      if (cif.bitslip_o === 1'b1) void'(bq.pop_front());
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], bq.pop_front()};
      cif.cin_data_i = b;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (cif.bitslip_o === 1'b1) begin
      if (prev_slip === 1'b1) begin
        total++;
        $display("FAIL bitslip_back_to_back: got 1 expected 0");
      end
      slips++;
      slip_cyc.push_back(cyc);
    end
    prev_slip = cif.bitslip_o;
    if (cif.command_valid_o === 1'b1) begin
      valids++;
      if (exp_q.size() > 0) begin
        chk("command", cif.command_o, exp_q.pop_front());
      end else begin
        total++;
        $display("FAIL unexpected_command: got %h expected none",
                 cif.command_o);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    cif.align_start_i = 1'b1;
    @(negedge clk);
    cif.align_start_i = 1'b0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_bitslip"}, {31'b0, cif.bitslip_o}, 0);
    chk({tag, "_locked"}, {31'b0, cif.locked_o}, 0);
    chk({tag, "_fail"}, {31'b0, cif.align_fail_o}, 0);
    chk({tag, "_cmd"}, cif.command_o, 0);
    chk({tag, "_valid"}, {31'b0, cif.command_valid_o}, 0);
`ifdef SURF_CIN_ERRCNT_EN
    chk({tag, "_errcnt"}, {16'b0, cif.errcnt_o}, 0);
`endif
  endtask

  initial begin
    cif.align_start_i = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    repeat (12) @(negedge clk);

    // aligned stream
    slips = 0;
    pulse_start();
    for (int i = 0; i < 200 && !cif.locked_o; i++) @(negedge clk);
    chk("aligned_locked", {31'b0, cif.locked_o}, 1);
    chk("aligned_slips", slips, 0);

    // single command among training words
    valids = 0;
    exp_q.push_back(32'h12345678);
    inj_q.push_back(32'h12345678);
    repeat (40) @(negedge clk);
    chk("cmd_count", valids, 1);
    chk("cmd_hold", cif.command_o, 32'h12345678);

    // reset while locked
    rst = 1'b1;
    #1;
    check_zero_outputs("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_relock", {31'b0, cif.locked_o}, 0);

    // 29-bit offset: 3 slips restore word alignment
    bq.delete();
    fill();
    repeat (29) void'(bq.pop_front());
    repeat (8) @(negedge clk);
    slips = 0;
    slip_cyc.delete();
    pulse_start();
    for (int i = 0; i < 400 && !cif.locked_o; i++) @(negedge clk);
    chk("misalign_locked", {31'b0, cif.locked_o}, 1);
    chk("misalign_slips", slips, 3);
    if (slip_cyc.size() >= 3) begin
      chk("slip_gap1", slip_cyc[1] - slip_cyc[0], 12);
      chk("slip_gap2", slip_cyc[2] - slip_cyc[1], 12);
    end else begin
      total++;
      $display("FAIL slip_gap: got %0d slips expected 3",
               slip_cyc.size());
    end

    // near-training words
    valids = 0;
    repeat (2) begin
      exp_q.push_back(32'hA55A0000);
      inj_q.push_back(32'hA55A0000);
    end
    repeat (60) @(negedge clk);
    chk("near_cmd_count", valids, 2);
`ifdef SURF_CIN_ERRCNT_EN
    chk("errcnt", {16'b0, cif.errcnt_o}, 2);
`endif

    // no training at all
    rst = 1'b1;
    zero_mode = 1'b1;
    bq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    slips = 0;
    pulse_start();
    for (int i = 0; i < 600 && !cif.align_fail_o; i++) @(negedge clk);
    chk("nofail_flag", {31'b0, cif.align_fail_o}, 1);
    chk("nofail_slips", slips, 8);
    chk("nofail_locked", {31'b0, cif.locked_o}, 0);
    repeat (50) @(negedge clk);
    chk("fail_idle_slips", slips, 8);
    chk("fail_sticky", {31'b0, cif.align_fail_o}, 1);
    pulse_start();
    chk("fail_cleared", {31'b0, cif.align_fail_o}, 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
